// File: rtl/peripheral_bfm_ahb4_pkg.sv
// Shared definitions for the AHB4-flavoured slave BFM: response and burst
// codes, the write/read engine state encodings, and the address window test.
package peripheral_bfm_ahb4_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

    // True when a byte offset (address minus base) lands inside a RAM of
    // 2^aw 32-bit words; offsets that wrapped below the base are huge and fail.
    function automatic logic off_in_range(input logic [31:0] off, input int unsigned aw);
        return (off >> (aw + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/peripheral_bfm_ram_ahb4.sv
// Word RAM for the slave BFM: one byte-strobed synchronous write port and
// one asynchronous read port. A same-cycle read of the word being written
// sees the old contents, since the write lands on the clock edge.
module peripheral_bfm_ram_ahb4 #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wstrb,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    // Byte-lane write; lanes with a clear strobe keep their contents.
    // NOTE: the array has no reset -- its contents must survive aresetn and a reset port would also block RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/peripheral_bfm_slave_ahb4.sv
// Memory-backed slave BFM answering AW/W/B and AR/R traffic from a word RAM.
// Independent write and read engines, one outstanding transaction each.
// Optional build macro PERIPHERAL_BFM_SLAVE_AHB4_STALL_EN adds address-phase
// wait states (STALL_CYCLES) and a one-cycle wready/rvalid gap every 4 beats.
module peripheral_bfm_slave_ahb4
    import peripheral_bfm_ahb4_pkg::*;
#(
    parameter int          MEM_AW       = 10,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          STALL_CYCLES = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  awid,
    input  logic [31:0] awadr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wrdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);

    wr_state_t   wr_state_q, wr_state_d;
    logic [3:0]  awid_q, awid_d, awlen_q, awlen_d, wcnt_q, wcnt_d;
    logic [31:0] waddr_q, waddr_d;
    logic [1:0]  awburst_q, awburst_d, bresp_q, bresp_d;
    logic        werr_q, werr_d, awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;

    rd_state_t   rd_state_q, rd_state_d;
    logic [3:0]  arid_q, arid_d, arlen_q, arlen_d, rcnt_q, rcnt_d;
    logic [31:0] raddr_q, raddr_d, rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;

    logic [31:0] w_off, r_fetch, r_off, ram_rdata, r_word;
    logic [1:0]  r_resp;
    logic        w_in_range, r_in_range, ram_we, w_last, w_err;

    // Sideband fields the BFM deliberately does not interpret.
    logic unused_inputs;
    assign unused_inputs = ^{awsize, awlock, awcache, awprot, wid, arsize, arlock, arcache, arprot};

`ifdef PERIPHERAL_BFM_SLAVE_AHB4_STALL_EN
    localparam logic [7:0] STALL_LIM = 8'(STALL_CYCLES);
    logic [7:0] aw_stall_q, aw_stall_d, ar_stall_q, ar_stall_d;
`else
    logic unused_stall;
    assign unused_stall = ^STALL_CYCLES;
`endif

    // Current write beat address, and the next read beat to pre-fetch.
    assign w_off      = waddr_q - BASE_ADDR;
    assign w_in_range = off_in_range(w_off, MEM_AW);
    assign r_fetch    = (rd_state_q == R_ADDR) ? araddr : raddr_q + 32'd4;
    assign r_off      = r_fetch - BASE_ADDR;
    assign r_in_range = off_in_range(r_off, MEM_AW);
    assign r_word     = r_in_range ? ram_rdata : 32'd0;
    assign r_resp     = r_in_range ? RESP_OKAY : RESP_SLVERR;

    peripheral_bfm_ram_ahb4 #(.AW(MEM_AW)) u_ram (
        .clk   (aclk),
        .we    (ram_we),
        .waddr (w_off[MEM_AW+1:2]),
        .wstrb (wstrb),
        .wdata (wrdata),
        .raddr (r_off[MEM_AW+1:2]),
        .rdata (ram_rdata)
    );

    // Write engine: awready pulse, data beats into RAM, then one response.
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        wr_state_d = wr_state_q;
        awid_d     = awid_q;
        awlen_d    = awlen_q;
        awburst_d  = awburst_q;
        waddr_d    = waddr_q;
        wcnt_d     = wcnt_q;
        werr_d     = werr_q;
        awready_d  = 1'b0;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        ram_we     = 1'b0;
        w_last     = 1'b0;
        w_err      = werr_q;
`ifdef PERIPHERAL_BFM_SLAVE_AHB4_STALL_EN
        aw_stall_d = '0;
`endif
        case (wr_state_q)
            W_IDLE: begin
                if (awvalid) begin
`ifdef PERIPHERAL_BFM_SLAVE_AHB4_STALL_EN
                    if (aw_stall_q == STALL_LIM) begin
                        wr_state_d = W_ADDR;
                        awready_d  = 1'b1;
                    end else begin
                        aw_stall_d = aw_stall_q + 8'd1;
                    end
`else
                    wr_state_d = W_ADDR;
                    awready_d  = 1'b1;
`endif
                end
            end
            W_ADDR: begin
                // awready is high for this one cycle; a withdrawn request is dropped.
                if (awvalid) begin
                    awid_d     = awid;
                    awlen_d    = awlen;
                    awburst_d  = awburst;
                    waddr_d    = awadr;
                    wcnt_d     = '0;
                    werr_d     = 1'b0;
                    wready_d   = 1'b1;
                    wr_state_d = W_DATA;
                end else begin
                    wr_state_d = W_IDLE;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q) begin
                    w_last = (wcnt_q == awlen_q);
                    w_err  = werr_q | ~w_in_range | (wlast != w_last);
                    ram_we = w_in_range;
                    if (w_last) begin
                        wready_d   = 1'b0;
                        bvalid_d   = 1'b1;
                        bresp_d    = w_err ? RESP_SLVERR : RESP_OKAY;
                        wr_state_d = W_RESP;
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                        werr_d = w_err;
                        case (awburst_q)
                            BURST_FIXED: waddr_d = waddr_q;
                            BURST_INCR:  waddr_d = waddr_q + 32'd4;
                            default:     waddr_d = waddr_q + 32'd4;  // reserved codes act as INCR
                        endcase
`ifdef PERIPHERAL_BFM_SLAVE_AHB4_STALL_EN
                        if (wcnt_q[1:0] == 2'b11) wready_d = 1'b0;
`endif
                    end
                end
`ifdef PERIPHERAL_BFM_SLAVE_AHB4_STALL_EN
                else if (!wready_q) begin
                    wready_d = 1'b1;
                end
`endif
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d   = 1'b0;
                    bresp_d    = RESP_OKAY;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read engine: arready pulse, then one registered beat per rready.
    always_comb begin
        rd_state_d = rd_state_q;
        arid_d     = arid_q;
        arlen_d    = arlen_q;
        raddr_d    = raddr_q;
        rcnt_d     = rcnt_q;
        arready_d  = 1'b0;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
`ifdef PERIPHERAL_BFM_SLAVE_AHB4_STALL_EN
        ar_stall_d = '0;
`endif
        case (rd_state_q)
            R_IDLE: begin
                if (arvalid) begin
`ifdef PERIPHERAL_BFM_SLAVE_AHB4_STALL_EN
                    if (ar_stall_q == STALL_LIM) begin
                        rd_state_d = R_ADDR;
                        arready_d  = 1'b1;
                    end else begin
                        ar_stall_d = ar_stall_q + 8'd1;
                    end
`else
                    rd_state_d = R_ADDR;
                    arready_d  = 1'b1;
`endif
                end
            end
            R_ADDR: begin
                if (arvalid) begin
                    arid_d     = arid;
                    arlen_d    = arlen;
                    raddr_d    = araddr;
                    rcnt_d     = '0;
                    rvalid_d   = 1'b1;
                    rdata_d    = r_word;
                    rresp_d    = r_resp;
                    rlast_d    = (arlen == 4'd0);
                    rd_state_d = R_DATA;
                end else begin
                    rd_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (rvalid_q && rready) begin
                    if (rcnt_q == arlen_q) begin
                        rvalid_d   = 1'b0;
                        rlast_d    = 1'b0;
                        rresp_d    = RESP_OKAY;
                        rdata_d    = '0;
                        rd_state_d = R_IDLE;
                    end else begin
                        rcnt_d  = rcnt_q + 4'd1;
                        raddr_d = raddr_q + 32'd4;
                        rdata_d = r_word;
                        rresp_d = r_resp;
                        rlast_d = ((rcnt_q + 4'd1) == arlen_q);
`ifdef PERIPHERAL_BFM_SLAVE_AHB4_STALL_EN
                        if (rcnt_q[1:0] == 2'b11) rvalid_d = 1'b0;
`endif
                    end
                end
`ifdef PERIPHERAL_BFM_SLAVE_AHB4_STALL_EN
                else if (!rvalid_q) begin
                    rvalid_d = 1'b1;
                end
`endif
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Write engine registers.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_q <= W_IDLE;
            awid_q     <= '0;
            awlen_q    <= '0;
            awburst_q  <= '0;
            waddr_q    <= '0;
            wcnt_q     <= '0;
            werr_q     <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            awid_q     <= awid_d;
            awlen_q    <= awlen_d;
            awburst_q  <= awburst_d;
            waddr_q    <= waddr_d;
            wcnt_q     <= wcnt_d;
            werr_q     <= werr_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
        end
    end

    // Read engine registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state_q <= R_IDLE;
            arid_q     <= '0;
            arlen_q    <= '0;
            raddr_q    <= '0;
            rcnt_q     <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            rlast_q    <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            arid_q     <= arid_d;
            arlen_q    <= arlen_d;
            raddr_q    <= raddr_d;
            rcnt_q     <= rcnt_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
        end
    end

`ifdef PERIPHERAL_BFM_SLAVE_AHB4_STALL_EN
    // Address-phase wait-state counters.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_stall_q <= '0;
            ar_stall_q <= '0;
        end else begin
            aw_stall_q <= aw_stall_d;
            ar_stall_q <= ar_stall_d;
        end
    end
`endif

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bid     = awid_q;
    assign bresp   = bresp_q;
    assign bvalid  = bvalid_q;
    assign arready = arready_q;
    assign rid     = arid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rvalid  = rvalid_q;

endmodule

// File: tb/tb_peripheral_bfm_slave_ahb4.sv
// Self-checking bench for peripheral_bfm_slave_ahb4. A word-array model of
// the RAM tracks every write beat (range, strobes, FIXED/INCR addressing)
// and predicts responses and read data. Honours
// PERIPHERAL_BFM_SLAVE_AHB4_STALL_EN for the expected latencies and gaps.
module tb_peripheral_bfm_slave_ahb4;
    import peripheral_bfm_ahb4_pkg::*;

    localparam int          MEM_AW       = 10;
    localparam logic [31:0] BASE_ADDR    = 32'h0000_0000;
    localparam int          STALL_CYCLES = 2;
    localparam int          DEPTH        = 1 << MEM_AW;
`ifdef PERIPHERAL_BFM_SLAVE_AHB4_STALL_EN
    localparam int ADDR_LAT = 2 + STALL_CYCLES;
    localparam bit STALL_ON = 1'b1;
`else
    localparam int ADDR_LAT = 2;
    localparam bit STALL_ON = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  awid, awlen, awcache, wid, wstrb, arid, arlen, arcache;
    logic [31:0] awadr, wrdata, araddr;
    logic [2:0]  awsize, awprot, arsize, arprot;
    logic [1:0]  awburst, awlock, arlock;
    logic        awvalid, wlast, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rlast, rvalid;
    logic [3:0]  bid, rid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] m_addr;
    logic [1:0]  m_burst;
    int          m_len, m_beat;
    bit          m_err;
    logic [31:0] wdata_a [16];
    logic [3:0]  wstrb_a [16];

    always #5 aclk = ~aclk;

    peripheral_bfm_slave_ahb4 #(
        .MEM_AW(MEM_AW), .BASE_ADDR(BASE_ADDR), .STALL_CYCLES(STALL_CYCLES)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awadr(awadr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return off < 32'(4 * DEPTH);
    endfunction

    function automatic int ref_index(input logic [31:0] a);
        return int'((a - BASE_ADDR) / 32'd4);
    endfunction

    // Wait (bounded) until the selected handshake signal is high at a falling edge.
    task automatic wait_sig(input string tag, input int sel, output int n);
        logic s;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
            case (sel)
                0:       s = awready;
                1:       s = wready;
                2:       s = bvalid;
                3:       s = arready;
                default: s = rvalid;
            endcase
        end while (!s && n < 200);
        check(tag, 64'(s), 64'd1);
    endtask

    task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input int len, input logic [1:0] burst);
        int n;
        @(posedge aclk);
        #1;
        awid = id; awadr = addr; awlen = 4'(len); awburst = burst;
        awsize = 3'($urandom); awlock = 2'($urandom); awcache = 4'($urandom); awprot = 3'($urandom);
        awvalid = 1'b1;
        wait_sig("aw_wait", 0, n);
        check("aw_latency", 64'(n), 64'(ADDR_LAT));
        @(posedge aclk);
        #1;
        awvalid = 1'b0;
        check("aw_pulse", 64'(awready), 64'd0);
        m_addr = addr; m_burst = burst; m_len = len; m_beat = 0; m_err = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        int n;
        logic [31:0] a, w;
        wid = 4'($urandom); wrdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        wait_sig("w_wait", 1, n);
        @(posedge aclk);
        #1;
        wvalid = 1'b0;
        wlast  = 1'b0;
        a = (m_burst == BURST_FIXED) ? m_addr : m_addr + 32'(4 * m_beat);
        if (ref_in_range(a)) begin
            w = model_mem[ref_index(a)];
            for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            model_mem[ref_index(a)] = w;
        end else begin
            m_err = 1'b1;
        end
        if (l != (m_beat == m_len)) m_err = 1'b1;
        m_beat++;
    endtask

    task automatic b_phase(input logic [3:0] id, input int hold);
        int n;
        wait_sig("b_wait", 2, n);
        check("bid", 64'(bid), 64'(id));
        check("bresp", 64'(bresp), m_err ? 64'h2 : 64'h0);
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            check("b_hold", 64'(bvalid), 64'd1);
        end
        bready = 1'b1;
        @(posedge aclk);
        #1;
        bready = 1'b0;
        check("b_done", 64'(bvalid), 64'd0);
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input int early, input int hold);
        aw_phase(id, addr, len, burst);
        for (int i = 0; i <= len; i++)
            w_beat(wdata_a[i], wstrb_a[i], (early >= 0) ? (i == early) : (i == len));
        b_phase(id, hold);
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int stall_beat, input int stall_cycles);
        int n, gaps;
        logic [31:0] a, exp_d;
        logic [1:0]  exp_r;
        @(posedge aclk);
        #1;
        arid = id; araddr = addr; arlen = 4'(len);
        arsize = 3'($urandom); arlock = 2'($urandom); arcache = 4'($urandom); arprot = 3'($urandom);
        arvalid = 1'b1;
        wait_sig("ar_wait", 3, n);
        check("ar_latency", 64'(n), 64'(ADDR_LAT));
        @(posedge aclk);
        #1;
        arvalid = 1'b0;
        check("ar_pulse", 64'(arready), 64'd0);
        gaps = 0;
        for (int i = 0; i <= len; i++) begin
            wait_sig("r_wait", 4, n);
            if (i > 0 && n > 1) gaps++;
            a     = addr + 32'(4 * i);
            exp_d = ref_in_range(a) ? model_mem[ref_index(a)] : 32'd0;
            exp_r = ref_in_range(a) ? 2'b00 : 2'b10;
            check("rid", 64'(rid), 64'(id));
            check("rdata", 64'(rdata), 64'(exp_d));
            check("rresp", 64'(rresp), 64'(exp_r));
            check("rlast", 64'(rlast), 64'(i == len));
            if (i == stall_beat) begin
                for (int k = 0; k < stall_cycles; k++) begin
                    @(negedge aclk);
                    check("r_hold", {29'd0, rvalid, rresp, rdata}, {29'd1, exp_r, exp_d});
                end
            end
            rready = 1'b1;
            @(posedge aclk);
            #1;
            rready = 1'b0;
        end
        check("r_done", 64'(rvalid), 64'd0);
        check("r_gaps", 64'(gaps), STALL_ON ? 64'(len / 4) : 64'd0);
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast});
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, early;
        logic [31:0] addr;
        logic [1:0]  burst;

        aresetn = 1'b0;
        awid = '0; awadr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = '0; awcache = '0; awprot = '0;
        awvalid = 1'b0; wid = '0; wrdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arlock = '0; arcache = '0; arprot = '0;
        arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("reset_outputs", all_outputs(), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;

        // Fill the whole RAM so every later read has a known expectation.
        for (int blk = 0; blk < DEPTH / 16; blk++) begin
            for (int i = 0; i < 16; i++) begin
                wdata_a[i] = $urandom;
                wstrb_a[i] = 4'hF;
            end
            axi_write(4'(blk), BASE_ADDR + 32'(blk * 64), 15, BURST_INCR, -1, 0);
        end

        // Single write then read.
        wdata_a[0] = 32'hDEAD_BEEF; wstrb_a[0] = 4'hF;
        axi_write(4'h5, 32'h10, 0, BURST_INCR, -1, 0);
        axi_read(4'h6, 32'h10, 0, -1, 0);
        check("single_rdata_model", 64'(model_mem[4]), 64'hDEAD_BEEF);

        // INCR burst of four.
        for (int i = 0; i < 4; i++) begin
            wdata_a[i] = 32'(i + 1);
            wstrb_a[i] = 4'hF;
        end
        axi_write(4'h1, 32'h100, 3, BURST_INCR, -1, 0);
        axi_read(4'h2, 32'h100, 3, -1, 0);

        // Byte strobes, then a FIXED burst.
        wdata_a[0] = 32'hFFFF_FFFF; wstrb_a[0] = 4'hF;
        axi_write(4'h3, 32'h20, 0, BURST_INCR, -1, 0);
        wdata_a[0] = 32'h0000_AB00; wstrb_a[0] = 4'h2;
        axi_write(4'h3, 32'h20, 0, BURST_INCR, -1, 0);
        axi_read(4'h4, 32'h20, 0, -1, 0);
        check("strobe_model", 64'(model_mem[8]), 64'hFFFF_ABFF);
        for (int i = 0; i < 3; i++) begin
            wdata_a[i] = 32'(7 + i);
            wstrb_a[i] = 4'hF;
        end
        axi_write(4'h7, 32'h40, 2, BURST_FIXED, -1, 0);
        axi_read(4'h8, 32'h40, 1, -1, 0);
        check("fixed_model", 64'(model_mem[16]), 64'd9);

        // Error paths: out-of-range write leaves word 0 alone; early wlast; out-of-range read.
        wdata_a[0] = 32'h1234_5678; wstrb_a[0] = 4'hF;
        axi_write(4'h9, 32'h0, 0, BURST_INCR, -1, 0);
        wdata_a[0] = 32'h0BAD_0BAD;
        axi_write(4'hA, 32'h1000, 0, BURST_INCR, -1, 0);
        axi_read(4'hB, 32'h0, 0, -1, 0);
        for (int i = 0; i < 4; i++) begin
            wdata_a[i] = $urandom;
            wstrb_a[i] = 4'hF;
        end
        axi_write(4'hC, 32'h200, 3, BURST_INCR, 1, 0);
        axi_read(4'hD, 32'h2000, 0, -1, 0);
        // Burst crossing the top of the window, and one wrapping past 2^32 into word 0.
        axi_write(4'hE, 32'hFF8, 3, BURST_INCR, -1, 0);
        axi_read(4'hE, 32'hFF8, 3, -1, 0);
        axi_write(4'hF, 32'hFFFF_FFFC, 1, BURST_INCR, -1, 0);
        axi_read(4'hF, 32'hFFFF_FFFC, 1, -1, 0);

        // Backpressure on R and B.
        axi_read(4'h2, 32'h100, 3, 1, 5);
        axi_write(4'h6, 32'h180, 1, BURST_INCR, -1, 3);

        // Sixteen-beat read (gap count under the stall build).
        axi_read(4'h1, 32'h400, 15, -1, 0);

        // Reset in the middle of a write burst.
        for (int i = 0; i < 4; i++) begin
            wdata_a[i] = $urandom;
            wstrb_a[i] = 4'hF;
        end
        aw_phase(4'h3, 32'h300, 3, BURST_INCR);
        w_beat(wdata_a[0], 4'hF, 1'b0);
        w_beat(wdata_a[1], 4'hF, 1'b0);
        aresetn = 1'b0;
        #1;
        check("reset_midburst", all_outputs(), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        axi_write(4'h4, 32'h308, 1, BURST_INCR, -1, 0);
        axi_read(4'h5, 32'h300, 3, -1, 0);

        // Randomised bursts, each read back with random R stalls.
        for (int it = 0; it < 16; it++) begin
            len   = $urandom_range(0, 15);
            burst = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                addr = BASE_ADDR + 32'(4 * DEPTH - 4 * $urandom_range(1, 8));
            else
                addr = BASE_ADDR + 32'(4 * $urandom_range(0, DEPTH - 17));
            early = (len > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : -1;
            for (int i = 0; i < 16; i++) begin
                wdata_a[i] = $urandom;
                wstrb_a[i] = 4'($urandom);
            end
            axi_write(4'($urandom), addr, len, burst, early, $urandom_range(0, 2));
            axi_read(4'($urandom), addr, len, $urandom_range(0, len), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
